// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard/interlock controller.
// Scoreboard entries mirror the EX/MEM/WB destination-register state.
package hazard_ctrl_pkg;

    localparam int SB_REG_AW = 5;

    typedef struct packed {
        logic                 valid;
        logic [SB_REG_AW-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } sb_entry_t;

    localparam logic [SB_REG_AW-1:0] REG_ZERO = '0;

    localparam sb_entry_t SB_BUBBLE = '{
        valid:    1'b0,
        rd:       '0,
        regwrite: 1'b0,
        memread:  1'b0
    };

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage register with hold, clear and load.
// Clear wins over hold so a stopped CPU always restarts empty.
module hazard_sb_entry
    import hazard_ctrl_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      clr_i,
    input  logic      hold_i,
    input  sb_entry_t d_i,
    output sb_entry_t q_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) begin
            q_o <= SB_BUBBLE;
        end else if (!hold_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/interlock controller with private EX/MEM/WB scoreboard,
// memory-busy freeze and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit FORWARDING = 1'b1,
    parameter int REG_AW     = SB_REG_AW,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              mem_busy_i,
    output logic              hazard_o,
    output logic              ifid_hold_o,
    output logic              idex_bubble_o,
    output logic              freeze_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb_unused;
    sb_entry_t ex_d;

    logic hit_ex;
    logic hit_mem;
    logic stall;
    logic freeze;
    logic clr;

    function automatic logic src_hit(
        input sb_entry_t         e,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              rs_used,
        input logic              rt_used
    );
        return e.valid && e.regwrite && (e.rd != REG_ZERO) &&
               ((rs_used && (rs == e.rd)) || (rt_used && (rt == e.rd)));
    endfunction

    assign hit_ex  = src_hit(sb_ex, id_rs_i, id_rt_i,
                             id_rs_used_i, id_rt_used_i);
    assign hit_mem = src_hit(sb_mem, id_rs_i, id_rt_i,
                             id_rs_used_i, id_rt_used_i);

    always_comb begin
        stall = 1'b0;
        if (FORWARDING) begin
            stall = start_i && id_valid_i && hit_ex && sb_ex.memread;
        end else begin
            stall = start_i && id_valid_i && (hit_ex || hit_mem);
        end
    end

    assign freeze = mem_busy_i && start_i;
    assign clr    = !start_i;

    always_comb begin
        ex_d = SB_BUBBLE;
        if (id_valid_i && !stall) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
    end

    hazard_sb_entry u_sb_ex (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .hold_i (freeze),
        .d_i    (ex_d),
        .q_o    (sb_ex)
    );

    hazard_sb_entry u_sb_mem (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .hold_i (freeze),
        .d_i    (sb_ex),
        .q_o    (sb_mem)
    );

    // WB is tracked for completeness; register file write-first hides it.
    hazard_sb_entry u_sb_wb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr),
        .hold_i (freeze),
        .d_i    (sb_mem),
        .q_o    (sb_wb_unused)
    );

    assign hazard_o      = start_i && (stall || freeze);
    assign ifid_hold_o   = start_i && (stall || freeze);
    assign idex_bubble_o = start_i && stall && !freeze;
    assign freeze_o      = freeze;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (start_i && stall && !freeze && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, no-forwarding and
// 4-bit-counter instances share one ID stimulus stream.
module tb_hazard_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_rs_used_i;
    logic       id_rt_used_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       mem_busy_i;

    logic        f_haz, f_hold, f_bub, f_frz;
    logic [31:0] f_cnt;
    logic        n_haz, n_hold, n_bub, n_frz;
    logic [31:0] n_cnt;
    logic        s_haz, s_hold, s_bub, s_frz;
    logic [3:0]  s_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.FORWARDING(1'b1), .REG_AW(5), .CNT_W(32)) u_fwd (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .mem_busy_i(mem_busy_i),
        .hazard_o(f_haz), .ifid_hold_o(f_hold), .idex_bubble_o(f_bub),
        .freeze_o(f_frz), .stall_cnt_o(f_cnt)
    );

    hazard_ctrl #(.FORWARDING(1'b0), .REG_AW(5), .CNT_W(32)) u_nofwd (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .mem_busy_i(mem_busy_i),
        .hazard_o(n_haz), .ifid_hold_o(n_hold), .idex_bubble_o(n_bub),
        .freeze_o(n_frz), .stall_cnt_o(n_cnt)
    );

    hazard_ctrl #(.FORWARDING(1'b1), .REG_AW(5), .CNT_W(4)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .mem_busy_i(mem_busy_i),
        .hazard_o(s_haz), .ifid_hold_o(s_hold), .idex_bubble_o(s_bub),
        .freeze_o(s_frz), .stall_cnt_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs,
                          input logic [4:0] rt, input logic rsu,
                          input logic rtu, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid_i    = v;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_rs_used_i  = rsu;
        id_rt_used_i  = rtu;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    task automatic id_nop();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic id_lw(input logic [4:0] rd);
        id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
    endtask

    task automatic id_alu(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_set(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_i      = 1'b0;
        start_i    = 1'b0;
        mem_busy_i = 1'b0;
        id_nop();
        tick();
        tick();
        rst_i   = 1'b1;
        start_i = 1'b1;
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_hazard", 32'(f_haz), 32'd0);
        chk("rst_hold",   32'(f_hold), 32'd0);
        chk("rst_bubble", 32'(f_bub), 32'd0);
        chk("rst_freeze", 32'(f_frz), 32'd0);
        chk("rst_cnt",    f_cnt, 32'd0);

        // load-use with forwarding
        id_lw(5'd8);
        settle();
        chk("lu_lw_nohaz", 32'(f_haz), 32'd0);
        tick();
        id_alu(5'd8, 5'd9, 5'd10);
        settle();
        chk("lu_hazard", 32'(f_haz), 32'd1);
        chk("lu_hold",   32'(f_hold), 32'd1);
        chk("lu_bubble", 32'(f_bub), 32'd1);
        tick();
        chk("lu_release", 32'(f_haz), 32'd0);
        chk("lu_rel_bub", 32'(f_bub), 32'd0);
        chk("lu_cnt",     f_cnt, 32'd1);
        tick();
        id_nop();
        tick();
        chk("lu_cnt_stay", f_cnt, 32'd1);

        // $0 destination and unused source
        do_reset();
        id_lw(5'd0);
        tick();
        id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        settle();
        chk("r0_nohaz", 32'(f_haz), 32'd0);
        tick();
        id_lw(5'd5);
        tick();
        id_set(1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        settle();
        chk("rtunused_nohaz", 32'(f_haz), 32'd0);
        tick();
        id_nop();
        settle();
        chk("r0_cnt", f_cnt, 32'd0);

        // RAW without forwarding
        do_reset();
        id_alu(5'd1, 5'd2, 5'd3);
        settle();
        chk("raw_first", 32'(n_haz), 32'd0);
        tick();
        id_alu(5'd3, 5'd4, 5'd6);
        settle();
        chk("raw_ex_haz", 32'(n_haz), 32'd1);
        chk("raw_ex_bub", 32'(n_bub), 32'd1);
        chk("raw_fwd_free", 32'(f_haz), 32'd0);
        tick();
        chk("raw_mem_haz", 32'(n_haz), 32'd1);
        chk("raw_mem_bub", 32'(n_bub), 32'd1);
        tick();
        chk("raw_wb_free", 32'(n_haz), 32'd0);
        tick();
        id_nop();
        settle();
        chk("raw_cnt", n_cnt, 32'd2);

        // freeze while load-use is pending
        do_reset();
        id_lw(5'd8);
        tick();
        id_alu(5'd8, 5'd9, 5'd10);
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("frz_freeze", 32'(f_frz), 32'd1);
            chk("frz_hazard", 32'(f_haz), 32'd1);
            chk("frz_bubble", 32'(f_bub), 32'd0);
            tick();
        end
        chk("frz_cnt_hold", f_cnt, 32'd0);
        mem_busy_i = 1'b0;
        settle();
        chk("frz_rel_haz", 32'(f_haz), 32'd1);
        chk("frz_rel_bub", 32'(f_bub), 32'd1);
        chk("frz_rel_frz", 32'(f_frz), 32'd0);
        tick();
        chk("frz_after", 32'(f_haz), 32'd0);
        chk("frz_cnt", f_cnt, 32'd1);

        // synchronous reset with a load in EX
        do_reset();
        id_lw(5'd8);
        tick();
        id_alu(5'd8, 5'd9, 5'd10);
        tick();
        tick();
        id_lw(5'd8);
        tick();
        chk("mrst_precnt", f_cnt, 32'd1);
        id_alu(5'd8, 5'd9, 5'd10);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        settle();
        chk("mrst_hazard", 32'(f_haz), 32'd0);
        chk("mrst_bubble", 32'(f_bub), 32'd0);
        chk("mrst_cnt",    f_cnt, 32'd0);

        // start drop mid-run keeps the counter
        do_reset();
        id_lw(5'd8);
        tick();
        id_alu(5'd8, 5'd9, 5'd10);
        tick();
        tick();
        id_lw(5'd8);
        tick();
        id_alu(5'd8, 5'd9, 5'd10);
        start_i    = 1'b0;
        mem_busy_i = 1'b1;
        settle();
        chk("stop_hazard", 32'(f_haz), 32'd0);
        chk("stop_bubble", 32'(f_bub), 32'd0);
        chk("stop_freeze", 32'(f_frz), 32'd0);
        tick();
        start_i    = 1'b1;
        mem_busy_i = 1'b0;
        settle();
        chk("restart_haz", 32'(f_haz), 32'd0);
        chk("restart_cnt", f_cnt, 32'd1);

        // saturation of the 4-bit counter
        do_reset();
        for (int i = 0; i < 20; i++) begin
            id_lw(5'd8);
            tick();
            id_alu(5'd8, 5'd9, 5'd10);
            settle();
            chk("sat_stall", 32'(s_bub), 32'd1);
            tick();
            tick();
            if (i == 14) chk("sat_at15", 32'(s_cnt), 32'd15);
        end
        id_nop();
        settle();
        chk("sat_final", 32'(s_cnt), 32'd15);
        chk("sat_wide",  f_cnt, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard/interlock controller for the 5-stage pipeline. It produces the stall request consumed by the PC register and the IF/ID latch, where 1 means hold.
- It also inserts bubbles into ID/EX.
- It keeps an internal scoreboard of the instructions in EX/MEM/WB, so stall decisions do not depend on fan-in from the later pipeline registers.
- It freezes the whole pipeline while data memory is busy, and counts stall cycles for performance debug.

Parameters:
- FORWARDING, 1: 1 means a full forwarding unit is present, so only load-use stalls. 0 means stall on any RAW hazard against EX or MEM.
- REG_AW, 5: register-address width.
- CNT_W, 32: stall-counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-low reset.
- start_i  in  1  CPU run enable. While 0 the scoreboard is cleared and all stall outputs are 0.
- id_valid_i  in  1  ID stage holds a real instruction (0 = NOP/flushed).
- id_rs_i  in  REG_AW  source register rs of the ID instruction.
- id_rt_i  in  REG_AW  source register rt of the ID instruction.
- id_rs_used_i  in  1  ID instruction reads rs.
- id_rt_used_i  in  1  ID instruction reads rt.
- id_rd_i  in  REG_AW  final destination register (after RegDst mux).
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- mem_busy_i  in  1  data memory has not completed; freezes the pipeline.
- hazard_o  out  1  hold PC (1 = hold).
- ifid_hold_o  out  1  hold IF/ID latch.
- idex_bubble_o  out  1  load a NOP into ID/EX this cycle.
- freeze_o  out  1  hold all pipeline registers (EX/MEM, MEM/WB included).
- stall_cnt_o  out  CNT_W  count of hazard-stall cycles.

Behaviour:
Scoreboard state:
- Three entries, EX, MEM and WB, each holding {valid, rd, regwrite, memread}.
- On reset, or when start_i=0, every entry clears to valid=0.

Match rules:
- src_hit(e) = e.valid & e.regwrite & (e.rd != 0) & ((id_rs_used_i & id_rs_i == e.rd) | (id_rt_used_i & id_rt_i == e.rd)).
- Register $0 never causes a hazard.

Stall and freeze:
- With FORWARDING=1: stall = id_valid_i & src_hit(EX) & EX.memread.
- With FORWARDING=0: stall = id_valid_i & (src_hit(EX) | src_hit(MEM)).
- WB is never a hazard, because the register file writes in the first half-cycle.
- freeze = mem_busy_i & start_i.

Outputs:
- All stall outputs are combinational from the registered scoreboard and current inputs, with zero latency.
- hazard_o = ifid_hold_o = start_i & (stall | freeze).
- idex_bubble_o = start_i & stall & ~freeze.
- freeze_o = freeze.

Scoreboard advance:
- If freeze: all entries hold.
- Otherwise: WB <= MEM, MEM <= EX.
- EX <= {1, id_rd_i, id_regwrite_i, id_memread_i} when id_valid_i & ~stall. Otherwise EX <= bubble (valid=0).

Simultaneous events:
- Freeze dominates stall: no bubble is inserted and the scoreboard does not shift. The stall is re-evaluated after the freeze is released.
- When the freeze releases on a cycle where the load-use condition holds, exactly one stall cycle follows.

Stall counter:
- Increments on each rising edge where start_i & stall & ~freeze.
- Saturates at all-ones; never wraps.
- Reset value 0; holds its value while start_i=0.

Reset and start:
- Synchronous reset mid-operation clears the scoreboard and counter on that edge. Outputs are 0 in the following cycle regardless of ID inputs.
- start_i=0 mid-run clears the scoreboard but keeps the counter.

Reset values:
- hazard_o=0, ifid_hold_o=0, idex_bubble_o=0, freeze_o=0, stall_cnt_o=0 (given start_i=0 or an empty scoreboard).

Decomposition:
- Shared package: REG_AW default; a scoreboard-entry struct {valid, rd, regwrite, memread}; constant for register zero; a bubble-entry constant.
- One natural sub-module: hazard_sb_entry, the per-stage register with hold/clear/load, instantiated three times.
- The match logic stays in the top level.

Test Plan:
1. Load-use, FORWARDING=1:
   - Stimulus: issue lw $8 (rd=8, memread=1); next cycle the ID instruction is add with rs=8.
   - Required: hazard_o=1, idex_bubble_o=1 for exactly 1 cycle; then 0; stall_cnt_o=1.
2. Register $0 and unused sources:
   - Stimulus: lw $0, then an instruction with rs=0; separately lw $5, then an instruction with rt=5 but id_rt_used_i=0.
   - Required: no stall in either case; counter stays 0.
3. FORWARDING=0 RAW:
   - Stimulus: add $3, then sub using rs=3.
   - Required: 2 stall cycles (EX hit, then MEM hit); released when the producer reaches WB; stall_cnt_o=2.
4. Freeze during load-use:
   - Stimulus: load-use condition present with mem_busy_i=1 for 3 cycles.
   - Required: freeze_o=1, hazard_o=1, idex_bubble_o=0 for those 3 cycles, scoreboard unchanged.
   - Required after release: 1 stall cycle with bubble; counter +1 only.
5. Reset and start mid-operation:
   - Stimulus: assert rst_i=0 for one edge while the scoreboard holds a load in EX.
   - Required: next cycle all outputs 0 and the counter is 0.
   - Stimulus: drive start_i=0 mid-run.
   - Required: outputs 0, counter retained, hazard-free restart.
6. Counter saturation:
   - Stimulus: CNT_W=4, 20 forced load-use stalls.
   - Required: stall_cnt_o stops at 15.
